// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] S_FETCH     = 4'd1;
    localparam logic [STATE_W-1:0] S_DECODE    = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd5;
    localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd6;
    localparam logic [STATE_W-1:0] S_R_EXEC    = 4'd7;
    localparam logic [STATE_W-1:0] S_R_WB      = 4'd8;
    localparam logic [STATE_W-1:0] S_I_EXEC    = 4'd9;
    localparam logic [STATE_W-1:0] S_I_WB      = 4'd10;
    localparam logic [STATE_W-1:0] S_BRANCH    = 4'd11;
    localparam logic [STATE_W-1:0] S_JUMP      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM sequencing the shared multi-cycle MIPS datapath.
// Latency: 3 (beq/j) to 5 (lw) cycles per instruction plus one per memory wait cycle.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold with strobes asserted until mem_ready.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               pc_en,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_d;
    logic               op_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        op_legal = 1'b1;
        case (state)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) state_d = S_MEM_ADDR;
                else if (Op == OP_RTYPE)        state_d = S_R_EXEC;
                else if (Op == OP_BEQ)          state_d = S_BRANCH;
                else if (Op == OP_J)            state_d = S_JUMP;
                else if (is_imm_op(Op))         state_d = S_I_EXEC;
                else begin
                    state_d  = S_FETCH;
                    op_legal = 1'b0;
                end
            end
            S_MEM_ADDR: begin
                if (Op == OP_LW)      state_d = S_MEM_READ;
                else if (Op == OP_SW) state_d = S_MEM_WRITE;
                else                  state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Moore decode; mem_ready gating in FETCH and illegal_op are the only input-dependent terms.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_IMM;
            end
            S_I_WB:      RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_en = PCWrite | (PCWriteCond & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction streams checked against an instruction-level model of the control FSM.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready, zero;
    logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    endfunction

    // Builds the expected state walk of one instruction from the instruction class and
    // wait counts, drives it, and checks per-state facts plus whole-instruction strobe counts.
    // zmode: 0/1 force zero, 2 random. rst_at >= 0 asserts rst_n mid-cycle at that step.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input int zmode, input int rst_at);
        logic [3:0] sq[$];
        bit         mq[$];
        bit is_lw, is_sw, is_r, is_i, is_beq, is_j, is_ill, zb;
        int c_mr = 0, c_mw = 0, c_ir = 0, c_pcw = 0, c_pcen = 0, c_rw = 0, c_ill = 0;
        is_lw  = (op == OP_LW);
        is_sw  = (op == OP_SW);
        is_r   = (op == OP_RTYPE);
        is_beq = (op == OP_BEQ);
        is_j   = (op == OP_J);
        is_i   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
                 (op == OP_XORI) || (op == OP_SLTI);
        is_ill = !(is_lw || is_sw || is_r || is_beq || is_j || is_i);
        zb = 1'b0;
        for (int k = 0; k < wf; k++) begin sq.push_back(S_FETCH); mq.push_back(1'b0); end
        sq.push_back(S_FETCH);  mq.push_back(1'b1);
        sq.push_back(S_DECODE); mq.push_back(1'($urandom));
        if (is_lw || is_sw) begin
            sq.push_back(S_MEM_ADDR); mq.push_back(1'($urandom));
            for (int k = 0; k < wm; k++) begin
                sq.push_back(is_lw ? S_MEM_READ : S_MEM_WRITE); mq.push_back(1'b0);
            end
            sq.push_back(is_lw ? S_MEM_READ : S_MEM_WRITE); mq.push_back(1'b1);
            if (is_lw) begin sq.push_back(S_MEM_WB); mq.push_back(1'($urandom)); end
        end else if (is_r) begin
            sq.push_back(S_R_EXEC); mq.push_back(1'($urandom));
            sq.push_back(S_R_WB);   mq.push_back(1'($urandom));
        end else if (is_i) begin
            sq.push_back(S_I_EXEC); mq.push_back(1'($urandom));
            sq.push_back(S_I_WB);   mq.push_back(1'($urandom));
        end else if (is_beq) begin
            sq.push_back(S_BRANCH); mq.push_back(1'($urandom));
        end else if (is_j) begin
            sq.push_back(S_JUMP);   mq.push_back(1'($urandom));
        end
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            Op        = (sq[i] == S_FETCH) ? 6'($urandom) : op;
            mem_ready = mq[i];
            zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            chk($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(sq[i]));
            c_mr += int'(MemRead);   c_mw += int'(MemWrite); c_ir += int'(IRWrite);
            c_pcw += int'(PCWrite);  c_pcen += int'(pc_en);  c_rw += int'(RegWrite);
            c_ill += int'(illegal_op);
            if (sq[i] == S_FETCH || sq[i] == S_MEM_READ)
                chk("read_iord", {30'd0, MemRead, IorD}, {30'd0, 1'b1, sq[i] == S_MEM_READ});
            if (sq[i] == S_MEM_WRITE) chk("write_iord", {30'd0, MemWrite, IorD}, 32'd3);
            if (sq[i] == S_R_EXEC) chk("r_aluop", 32'(ALUOp), 32'(2'b10));
            if (sq[i] == S_R_WB)   chk("r_wb", {30'd0, RegWrite, RegDst}, 32'd3);
            if (sq[i] == S_I_EXEC) chk("i_exec", {28'd0, ALUOp, ALUSrcB}, 32'b1110);
            if (sq[i] == S_I_WB)   chk("i_wb", {30'd0, RegWrite, RegDst}, 32'd2);
            if (sq[i] == S_MEM_WB) chk("mem_wb", {30'd0, RegWrite, MemtoReg}, 32'd3);
            if (sq[i] == S_BRANCH) begin
                zb = zero;
                chk("br_ctl", {28'd0, ALUOp, PCSource}, 32'b0101);
                chk("br_pc_en", 32'(pc_en), 32'(zero));
            end
            if (sq[i] == S_JUMP) chk("j_pcsrc", 32'(PCSource), 32'(2'b10));
            if (sq[i] == S_DECODE) chk("illegal_op", 32'(illegal_op), 32'(is_ill));
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_state", 32'(state), 32'(S_IDLE));
                chk("async_rst_outs", all_outs(), 32'd0);
                return;
            end
        end
        chk("cnt_memread", c_mr, wf + 1 + (is_lw ? wm + 1 : 0));
        chk("cnt_memwrite", c_mw, is_sw ? wm + 1 : 0);
        chk("cnt_irwrite", c_ir, 1);
        chk("cnt_pcwrite", c_pcw, 1 + int'(is_j));
        chk("cnt_pc_en", c_pcen, 1 + int'(is_j) + int'(is_beq && zb));
        chk("cnt_regwrite", c_rw, (is_r || is_i || is_lw) ? 1 : 0);
        chk("cnt_illegal", c_ill, int'(is_ill));
    endtask

    logic [5:0] ops [12];

    initial begin
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI,
                OP_XORI, OP_SLTI, 6'b111111, 6'b010001};
        rst_n = 1'b0; Op = '0; mem_ready = 1'b0; zero = 1'b0;
        #12;
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", 32'(state), 32'(S_IDLE));
        chk("idle_outs", all_outs(), 32'd0);

        run_instr(OP_RTYPE, 0, 0, 2, -1);
        run_instr(OP_LW, 0, 2, 2, -1);
        run_instr(OP_BEQ, 0, 0, 1, -1);
        run_instr(OP_BEQ, 0, 0, 0, -1);
        run_instr(OP_ORI, 1, 0, 2, -1);
        run_instr(6'b111111, 0, 0, 2, -1);
        run_instr(OP_J, 0, 0, 2, -1);
        run_instr(OP_SW, 2, 1, 2, -1);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] rop;
            rop = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3), 2, -1);
        end

        // sw with a long write wait; reset lands on the second wait cycle (step 4).
        run_instr(OP_SW, 0, 5, 2, 4);
        @(negedge clk);
        #1;
        chk("held_rst_state", 32'(state), 32'(S_IDLE));
        chk("held_rst_memwrite", 32'(MemWrite), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("released_state", 32'(state), 32'(S_IDLE));
        run_instr(OP_RTYPE, 0, 0, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
